// File: rtl/mips_avalon_pkg.sv
// Shared types for the MIPS Avalon bus fabric.
// Arbiter state, registered slave command bundle and boot address.
package mips_avalon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
        logic        read;
        logic        write;
    } avalon_cmd_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // A write always beats a read raised in the same cycle.
    function automatic avalon_cmd_t make_cmd(
        input logic [31:0] address,
        input logic [31:0] writedata,
        input logic [3:0]  byteenable,
        input logic        read,
        input logic        write
    );
        avalon_cmd_t c;
        c.address    = address;
        c.writedata  = writedata;
        c.byteenable = byteenable;
        c.read       = read & ~write;
        c.write      = write;
        return c;
    endfunction

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the master that was not served last wins.
module mips_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);

    assign any_req = |req;

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (req == 2'b11): grant = ~last_grant;
            (req == 2'b10): grant = 1'b1;
            default:        grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Shares one Avalon slave between instruction fetch (M0) and data (M1).
// Registered command toward the slave, watchdog-aborted stuck transfers.
module mips_avalon_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic        timeout
);
    import mips_avalon_pkg::*;

    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam int WDW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LAST_I =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [WDW-1:0] WD_LAST = WD_LAST_I[WDW-1:0];

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            grant_q;
    logic            last_grant;
    logic [WDW-1:0]  wd_count;
    avalon_cmd_t     cmd_q;
    avalon_cmd_t     cmd_sel;

    logic [1:0]      req;
    logic            arb_grant;
    logic            any_req;
    logic            busy;
    logic            done;
    logic            abort;
    logic            release_m;
    logic [31:0]     rdata;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    mips_rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    always_comb begin
        if (arb_grant) begin
            cmd_sel = make_cmd(m1_address, m1_writedata,
                               m1_byteenable, m1_read, m1_write);
        end else begin
            cmd_sel = make_cmd(m0_address, m0_writedata,
                               m0_byteenable, m0_read, m0_write);
        end
    end

    assign busy  = (state == BUSY);
    assign done  = busy & ~s_waitrequest;
    assign abort = WD_EN & busy & s_waitrequest
                 & (wd_count == WD_LAST);
    assign release_m = done | abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (release_m) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command bundle is captured once on the grant edge and then frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            wd_count   <= '0;
            cmd_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        cmd_q      <= cmd_sel;
                        grant_q    <= arb_grant;
                        last_grant <= arb_grant;
                        wd_count   <= '0;
                    end
                end
                BUSY: begin
                    if (release_m) begin
                        cmd_q.read  <= 1'b0;
                        cmd_q.write <= 1'b0;
                    end else begin
                        wd_count <= wd_count + WDW'(1);
                    end
                end
                default: begin
                    cmd_q.read  <= 1'b0;
                    cmd_q.write <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = abort ? 32'h0 : s_readdata;

    always_comb begin
        m0_waitrequest = 1'b1;
        m0_readdata    = 32'h0;
        m1_waitrequest = 1'b1;
        m1_readdata    = 32'h0;
        if (release_m) begin
            if (grant_q) begin
                m1_waitrequest = 1'b0;
                m1_readdata    = rdata;
            end else begin
                m0_waitrequest = 1'b0;
                m0_readdata    = rdata;
            end
        end
    end

    assign timeout      = abort;
    assign s_address    = cmd_q.address;
    assign s_read       = cmd_q.read;
    assign s_write      = cmd_q.write;
    assign s_writedata  = cmd_q.writedata;
    assign s_byteenable = cmd_q.byteenable;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboard bench for mips_avalon_arbiter with a random-latency RAM slave.
// Expected responses queue per master; a negedge monitor pops and compares.
module tb_mips_avalon_arbiter;
    import mips_avalon_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic        timeout;

    always #5 clk = ~clk;

    mips_avalon_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5C3_0F69;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old,
                                          logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // RAM slave with 0..3 stall cycles, or stuck forever
    logic [31:0] smem [bit [29:0]];
    bit          stuck = 1'b0;
    int          force_delay = -1;
    bit          s_active = 1'b0;
    int          stall_left = 0;
    bit          pend_w = 1'b0;
    logic [31:0] pend_a, pend_d;
    logic [3:0]  pend_be;

    function automatic logic [31:0] slave_rd(logic [31:0] a);
        if (smem.exists(a[31:2])) return smem[a[31:2]];
        return init_word(a);
    endfunction

    initial begin
        s_waitrequest = 1'b1;
        s_readdata    = 32'h0;
        forever begin
            @(posedge clk);
            if (pend_w && !rst)
                smem[pend_a[31:2]] = merge(slave_rd(pend_a), pend_d, pend_be);
            #1;
            pend_w = 1'b0;
            if (s_read || s_write) begin
                if (!s_active) begin
                    s_active = 1'b1;
                    if (stuck) stall_left = 1 << 20;
                    else if (force_delay >= 0) stall_left = force_delay;
                    else stall_left = $urandom_range(0, 3);
                end else if (stall_left > 0) begin
                    stall_left--;
                end
                s_waitrequest = (stall_left > 0);
                s_readdata = s_read ? slave_rd(s_address) : $urandom;
                if (!s_waitrequest && s_write) begin
                    pend_w  = 1'b1;
                    pend_a  = s_address;
                    pend_d  = s_writedata;
                    pend_be = s_byteenable;
                end
            end else begin
                s_active      = 1'b0;
                s_waitrequest = 1'($urandom_range(0, 1));
                s_readdata    = $urandom;
            end
        end
    end

    // Reference memory and per-master expectation queues
    logic [31:0] model [bit [29:0]];

    function automatic logic [31:0] model_rd(logic [31:0] a);
        if (model.exists(a[31:2])) return model[a[31:2]];
        return init_word(a);
    endfunction

    typedef struct {
        bit          is_read;
        bit          to;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic logic get_wait(int i);
        return (i == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    task automatic drive(int i, bit rd, bit wr, logic [31:0] a,
                         logic [31:0] d, logic [3:0] be);
        if (i == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a;
            m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a;
            m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic xfer(int i, bit rd, bit wr, logic [31:0] a,
                        logic [31:0] d, logic [3:0] be, bit exp_to);
        exp_t e;
        int n;
        e.to = exp_to;
        e.is_read = exp_to | (rd & ~wr);
        e.data = exp_to ? 32'h0 : model_rd(a);
        if (wr && !exp_to) model[a[31:2]] = merge(model_rd(a), d, be);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
        drive(i, rd, wr, a, d, be);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (get_wait(i) && n < 100);
        n_cmp++;
        if (get_wait(i)) begin
            n_bad++;
            $display("FAIL xfer_bound m%0d: waitrequest still 1, required 0 within 100 cycles", i);
        end
        @(posedge clk);
        #1;
        drive(i, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
    endtask

    task automatic rand_master(int i, int n, int maxgap);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int op;
            a = ((i == 0) ? 32'h1000_0000 : 32'h2000_0000)
                + 32'($urandom_range(0, 7) << 2);
            op = $urandom_range(0, 2);
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            xfer(i, op != 1, op != 0, a, $urandom, 4'($urandom), 1'b0);
        end
    endtask

    // Monitor: scoreboard pops plus round-robin order from request history
    int  last_done;
    int  last_cyc;
    bit  started [2];
    int  st [2];
    bit  prev_rel;

    task automatic on_release(int i, logic [31:0] rd);
        exp_t e;
        int s0, s1, a, ex;
        bit w0, w1;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_release m%0d: waitrequest 0, required 1", i);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("timeout_m%0d", i), 32'(timeout), 32'(e.to));
            if (e.is_read) check($sformatf("rdata_m%0d", i), rd, e.data);
        end
        s0 = started[0] ? st[0] : 32'h3fff_ffff;
        s1 = started[1] ? st[1] : 32'h3fff_ffff;
        a  = (s0 < s1) ? s0 : s1;
        if (a < last_cyc + 1) a = last_cyc + 1;
        w0 = (s0 <= a);
        w1 = (s1 <= a);
        ex = (w0 && w1) ? 1 - last_done : (w0 ? 0 : 1);
        check("arb_order", 32'(i), 32'(ex));
        last_done  = i;
        last_cyc   = cyc;
        started[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        bit rel0, rel1;
        if (rst) begin
            started[0] = 1'b0;
            started[1] = 1'b0;
            last_done  = 1;
            last_cyc   = cyc;
            prev_rel   = 1'b0;
        end else begin
            rel0 = !m0_waitrequest;
            rel1 = !m1_waitrequest;
            if (prev_rel) check("idle_gap", 32'({s_read, s_write}), 32'h0);
            check("rd_wr_excl", 32'(s_read & s_write), 32'h0);
            if (timeout && !rel0 && !rel1)
                check("timeout_alone", 32'(timeout), 32'h0);
            if (rel0) on_release(0, m0_readdata);
            else check("idle_rdata_m0", m0_readdata, 32'h0);
            if (rel1) on_release(1, m1_readdata);
            else check("idle_rdata_m1", m1_readdata, 32'h0);
            if (!rel0 && (m0_read || m0_write) && !started[0]) begin
                started[0] = 1'b1;
                st[0] = cyc;
            end
            if (!rel1 && (m1_read || m1_write) && !started[1]) begin
                started[1] = 1'b1;
                st[1] = cyc;
            end
            prev_rel = rel0 | rel1;
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_bound: simulation did not finish, required completion");
        $fatal(1, "global time limit");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_read", 32'(s_read), 32'h0);
        check("rst_s_write", 32'(s_write), 32'h0);
        check("rst_s_address", s_address, 32'h0);
        check("rst_s_writedata", s_writedata, 32'h0);
        check("rst_s_be", 32'(s_byteenable), 32'h0);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // boot fetch with fixed latency, 1-cycle arbitration latency
        force_delay = 3;
        fork
            xfer(0, 1'b1, 1'b0, RESET_VECTOR, 32'h0, 4'hF, 1'b0);
            begin
                @(negedge clk);
                check("lat_pre_s_read", 32'(s_read), 32'h0);
                @(negedge clk);
                check("lat_post_s_read", 32'(s_read), 32'h1);
                check("lat_s_address", s_address, RESET_VECTOR);
            end
        join
        force_delay = -1;

        // simultaneous requests after reset: M0 first, then M1
        pulse_reset();
        fork
            xfer(0, 1'b1, 1'b0, RESET_VECTOR, 32'h0, 4'hF, 1'b0);
            xfer(1, 1'b0, 1'b1, RESET_VECTOR + 4, 32'hDEADBEEF, 4'b0111, 1'b0);
        join
        xfer(0, 1'b1, 1'b0, RESET_VECTOR + 4, 32'h0, 4'hF, 1'b0);

        // continuous contention alternates grants
        fork
            rand_master(0, 3, 0);
            rand_master(1, 3, 0);
        join

        // randomized mix, including read+write and empty byteenable
        fork
            rand_master(0, 40, 3);
            rand_master(1, 40, 3);
        join

        // stuck slave: watchdog aborts M1 read
        stuck = 1'b1;
        xfer(1, 1'b1, 1'b0, 32'h2000_0040, 32'h0, 4'hF, 1'b1);
        stuck = 1'b0;
        xfer(1, 1'b1, 1'b0, 32'h2000_0044, 32'h0, 4'hF, 1'b0);

        // reset during the second BUSY cycle of an M1 write
        stuck = 1'b1;
        drive(1, 1'b0, 1'b1, RESET_VECTOR + 8, 32'h1234_5678, 4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("rstmid_s_write", 32'(s_write), 32'h0);
        check("rstmid_m0_wait", 32'(m0_waitrequest), 32'h1);
        check("rstmid_m1_wait", 32'(m1_waitrequest), 32'h1);
        @(posedge clk);
        #1;
        xfer(0, 1'b1, 1'b0, RESET_VECTOR + 8, 32'h0, 4'hF, 1'b0);

        // read and write together: write wins toward the slave
        fork
            xfer(0, 1'b1, 1'b1, RESET_VECTOR + 12, 32'hCAFE_F00D, 4'hF, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                check("rw_s_write", 32'(s_write), 32'h1);
                check("rw_s_read", 32'(s_read), 32'h0);
            end
        join
        xfer(0, 1'b1, 1'b0, RESET_VECTOR + 12, 32'h0, 4'hF, 1'b0);

        repeat (3) @(posedge clk);
        check("queues_drained", 32'(q0.size() + q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_avalon_arbiter.md
Name: mips_avalon_arbiter

Overview:
- Shares a single Avalon memory-mapped slave (the RAM model, mips_avalon_slave) between two Avalon masters.
  - M0 is CPU instruction fetch.
  - M1 is CPU data load/store.
- Round-robin arbitration. The granted command is registered and held stable for the slave until the slave drops waitrequest.
- A watchdog aborts stuck transfers and reports them.
- Sits between the MIPS core's two bus ports and the single memory port in the CPU-level testbench and top level.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles the slave may hold waitrequest per transfer; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- m0_address / m1_address  input  32  master byte address
- m0_read / m1_read  input  1  read request
- m0_write / m1_write  input  1  write request
- m0_writedata / m1_writedata  input  32  write data
- m0_byteenable / m1_byteenable  input  4  byte lanes
- m0_waitrequest / m1_waitrequest  output  1  stall to master
- m0_readdata / m1_readdata  output  32  read data to master
- s_address  output  32  registered address to slave
- s_read  output  1  registered read to slave
- s_write  output  1  registered write to slave
- s_writedata  output  32  registered write data to slave
- s_byteenable  output  4  registered byte lanes to slave
- s_waitrequest  input  1  slave stall
- s_readdata  input  32  slave read data
- timeout  output  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- States: IDLE, BUSY. Registers: grant (0/1), last_grant, wd_count (width $clog2(TIMEOUT_CYCLES+1), min 1).
- Reset (sync, rst=1 at edge), in all states including mid-transfer:
  - state=IDLE, last_grant=1 (so M0 wins the first tie), wd_count=0.
  - s_read=s_write=0, s_address=s_writedata=0, s_byteenable=0, timeout=0.
  - m0/m1_waitrequest=1 and m0/m1_readdata=0 while IDLE.
  - An aborted transfer is dropped; no completion is signalled.
- A master requests when read|write is high. If both read and write are high, write wins and read is suppressed toward the slave.
- IDLE:
  - No request: stay IDLE.
  - One requester: grant it.
  - Both requesting: grant the master other than last_grant.
  - On the grant edge: latch address/writedata/byteenable/command into the s_* registers, set grant and last_grant, wd_count=0, go to BUSY.
  - The slave sees the command from the cycle after the master first asserted its request (1-cycle arbitration latency).
- BUSY, normal completion (s_waitrequest=0):
  - In that same cycle, combinationally: m<grant>_waitrequest=0 and m<grant>_readdata=s_readdata.
  - At the edge: s_read=s_write=0, state=IDLE.
  - Consequence: one idle bus cycle between transfers; back-to-back requests alternate when both masters are active.
- BUSY, stalled (s_waitrequest=1):
  - wd_count increments.
  - If TIMEOUT_CYCLES≠0 and wd_count==TIMEOUT_CYCLES-1 in a stalled cycle, abort:
    - That cycle: m<grant>_waitrequest=0, m<grant>_readdata=0, timeout=1.
    - At the edge: s_read=s_write=0, state=IDLE.
- Non-granted master: waitrequest=1 and readdata=0 at all times. Its request is held pending, never lost.
- The master must hold its signals while its waitrequest=1. Changes to master inputs while BUSY have no effect (the command is already registered).
- A byteenable of 4'b0000 is forwarded unchanged. The arbiter does no address decode or offset arithmetic.
- No combinational path from m*_ inputs to s_* outputs. The only combinational paths are s_waitrequest/s_readdata → m*_waitrequest/m*_readdata and timeout.

Decomposition:
- Package mips_avalon_pkg:
  - typedef enum arb_state_t {IDLE, BUSY}
  - typedef struct avalon_cmd_t {address, writedata, byteenable, read, write}
  - localparam RESET_VECTOR=32'hBFC00000, for benches
- Sub-module mips_rr_arb2: purely combinational. Inputs: req[1:0], last_grant. Outputs: grant, any_req. Reusable for later bus bridges.

Test Plan:
- Reset, then M0 read at 0xBFC00000, slave delay 3 → s_read rises 1 cycle after m0_read; m0_waitrequest low exactly one cycle; m0_readdata equals the slave word; M1 sees waitrequest=1 throughout.
- M0 read and M1 write (0xBFC00004, 0xDEADBEEF, be=4'b0111) asserted in the same cycle → M0 served first (last_grant reset =1), then M1. A later M0 read of 0xBFC00004 returns 0x??ADBEEF, with the top byte unchanged.
- Both masters requesting continuously for 6 transfers → grants alternate M0, M1, M0, …; one idle cycle between each.
- TIMEOUT_CYCLES=4 with a slave model holding waitrequest=1 forever → after 4 stalled cycles: timeout=1 for one cycle, m1_waitrequest=0, m1_readdata=0, state back to IDLE.
- rst asserted in the second BUSY cycle of an M1 write → next cycle s_write=0, both m*_waitrequest=1; a following M0 read completes normally.
- M0 asserts read=write=1 → slave sees s_write=1, s_read=0.
